// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared operation codes, FSM states and helpers for the load/store unit.
package load_store_unit_pkg;
  typedef enum logic [1:0] {MEM_LW, MEM_LBU, MEM_SW, MEM_SB} mem_op_e;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} lsu_state_e;
  localparam int MEM_TIMEOUT_DEFAULT = 255;
  function automatic logic is_store(mem_op_e op);
    return op == MEM_SW || op == MEM_SB;
  endfunction
  function automatic logic misaligned(mem_op_e op, logic [1:0] off);
    return (op == MEM_LW || op == MEM_SW) && off != 2'b00;
  endfunction
endpackage

// File: rtl/load_store_unit_byte_lane_mux.sv
// byte_lane_mux: selects a load byte (zero-extended) and replicates a store byte across all lanes.
module byte_lane_mux (
  input  logic [31:0] rdata_i,
  input  logic [1:0]  sel_i,
  input  logic [7:0]  wbyte_i,
  output logic [31:0] rbyte_o,
  output logic [31:0] wrep_o
);
  assign rbyte_o = {24'b0, rdata_i[{sel_i, 3'b000} +: 8]};
  assign wrep_o  = {4{wbyte_i}};
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding data-memory access FSM with byte lanes and a load timeout.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  mem_op_e     op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        done_o,
  output logic [31:0] load_data_o,
  output logic        err_o
);
  lsu_state_e  state_q, state_d;
  mem_op_e     op_q, op_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, load_data_q, load_data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rbyte, wrep;
  byte_lane_mux u_lanes (
    .rdata_i(mem_rdata_i),
    .sel_i  (addr_q[1:0]),
    .wbyte_i(wdata_q[7:0]),
    .rbyte_o(rbyte),
    .wrep_o (wrep)
  );
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: if (valid_i) begin
        op_d    = op_i;
        addr_d  = addr_i;
        wdata_d = wdata_i;
        state_d = misaligned(op_i, addr_i[1:0]) ? ERR : REQ;
      end
      REQ: if (mem_gnt_i) begin
        state_d = is_store(op_q) ? DONE : WAIT;
        cnt_d   = '0;
      end
      WAIT: if (mem_rvalid_i) begin
        load_data_d = op_q == MEM_LW ? mem_rdata_i : rbyte;
        state_d     = DONE;
      end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
        state_d = ERR;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= MEM_LW;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
    end
  end
  assign ready_o     = state_q == IDLE;
  assign stall_o     = (valid_i && state_q == IDLE) || state_q == REQ || state_q == WAIT;
  assign mem_req_o   = state_q == REQ;
  assign mem_we_o    = is_store(op_q);
  assign mem_addr_o  = {addr_q[31:2], 2'b00};
  assign mem_be_o    = op_q == MEM_SB ? 4'b0001 << addr_q[1:0] : 4'b1111;
  assign mem_wdata_o = op_q == MEM_SB ? wrep : wdata_q;
  assign done_o      = state_q == DONE;
  assign err_o       = state_q == ERR;
  assign load_data_o = load_data_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized transaction-level checks of load_store_unit against a timing/data model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;
  localparam int T = 4;
  logic clk = 0, reset = 1, valid_i = 0, mem_gnt_i = 0, mem_rvalid_i = 0;
  mem_op_e op_i = MEM_LW;
  logic [31:0] addr_i = 0, wdata_i = 0, mem_rdata_i = 0;
  logic ready_o, stall_o, mem_req_o, mem_we_o, done_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, load_data_o;
  logic [3:0] mem_be_o;
  int vec = 0, miss = 0;
  logic [31:0] ref_ld = 0;
  always #5 clk = ~clk;
  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .ready_o(ready_o), .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .done_o(done_o), .load_data_o(load_data_o), .err_o(err_o)
  );
  // g = REQ cycles before grant, d = WAIT cycles before rvalid (d >= T means rvalid never comes)
  task automatic do_op(input mem_op_e op, input logic [31:0] addr, wdata, rdata, input int g, d);
    logic ld, mis, ok, in_req, in_wait;
    logic [31:0] exp_ld, exp_wd;
    logic [3:0] exp_be;
    int kend;
    ld     = op == MEM_LW || op == MEM_LBU;
    mis    = (op == MEM_LW || op == MEM_SW) && addr[1:0] != 0;
    ok     = !mis && (!ld || d < T);
    kend   = mis ? 1 : !ld ? 2 + g : d < T ? 3 + g + d : 2 + g + T;
    exp_ld = op == MEM_LW ? rdata : (rdata >> (8 * addr[1:0])) & 32'hff;
    exp_be = op == MEM_SB ? 4'(1 << addr[1:0]) : 4'hf;
    exp_wd = op == MEM_SB ? {4{wdata[7:0]}} : wdata;
    @(negedge clk);
    valid_i = 1; op_i = op; addr_i = addr; wdata_i = wdata; mem_gnt_i = 0; mem_rvalid_i = 0;
    #1;
    vec++;
    if (ready_o !== 1'b1 || stall_o !== 1'b1) begin
      miss++;
      $display("FAIL accept: ready=%b stall=%b, required 1/1", ready_o, stall_o);
    end
    for (int k = 1; k <= kend; k++) begin
      @(negedge clk);
      valid_i = 0; op_i = mem_op_e'(2'($urandom)); addr_i = $urandom; wdata_i = $urandom;
      in_req  = !mis && k <= 1 + g;
      in_wait = !mis && ld && k > 1 + g && k < kend;
      mem_gnt_i    = in_req && k == 1 + g;
      mem_rvalid_i = (ld && d < T && k == 2 + g + d) || ((k < 2 + g || k >= kend) && 1'($urandom));
      mem_rdata_i  = (k == 2 + g + d) ? rdata : $urandom;
      #1;
      if (ok && ld && k == kend) ref_ld = exp_ld;
      vec++;
      if (mem_req_o !== in_req || done_o !== (ok && k == kend) || err_o !== (!ok && k == kend) ||
          stall_o !== (in_req || in_wait) || load_data_o !== ref_ld) begin
        miss++;
        $display("FAIL op%0d cyc%0d: req=%b done=%b err=%b stall=%b ld=%h, required %b %b %b %b %h",
                 op, k, mem_req_o, done_o, err_o, stall_o, load_data_o,
                 in_req, ok && k == kend, !ok && k == kend, in_req || in_wait, ref_ld);
      end
      if (in_req) begin
        vec++;
        if (mem_addr_o !== {addr[31:2], 2'b00} || mem_we_o !== !ld || mem_be_o !== exp_be ||
            (!ld && mem_wdata_o !== exp_wd)) begin
          miss++;
          $display("FAIL bus op%0d cyc%0d: addr=%h we=%b be=%b wd=%h, required %h %b %b %h",
                   op, k, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
                   {addr[31:2], 2'b00}, !ld, exp_be, exp_wd);
        end
      end
    end
    mem_gnt_i = 0; mem_rvalid_i = 0;
  endtask
  task automatic test_reset;
    reset = 1;
    repeat (3) begin
      @(negedge clk);
      valid_i = 1'($urandom); op_i = mem_op_e'(2'($urandom)); mem_gnt_i = 1'($urandom);
    end
    @(negedge clk);
    reset = 0; valid_i = 0; mem_gnt_i = 0;
    #1;
    vec++;
    if (ready_o !== 1 || stall_o !== 0 || mem_req_o !== 0 || done_o !== 0 || err_o !== 0 || load_data_o !== 0) begin
      miss++;
      $display("FAIL reset: ready=%b stall=%b req=%b done=%b err=%b ld=%h, required 1 0 0 0 0 0",
               ready_o, stall_o, mem_req_o, done_o, err_o, load_data_o);
    end
    ref_ld = 0;
  endtask
  task automatic test_directed;
    do_op(MEM_SW, 32'h100, 32'hdeadbeef, 0, 0, 0);
    do_op(MEM_SB, 32'h103, 32'h000000a5, 0, 0, 0);
    do_op(MEM_LBU, 32'h202, 0, 32'h11223344, 3, 0);
    do_op(MEM_LW, 32'h101, 0, 0, 0, 0);
    do_op(MEM_SW, 32'h102, 32'h1, 0, 0, 0);
  endtask
  task automatic test_timeout;
    do_op(MEM_LW, 32'h400, 0, 32'hcafef00d, 0, T);
    do_op(MEM_LW, 32'h404, 0, 32'h0badc0de, 1, T - 1);
    do_op(MEM_LBU, 32'h409, 0, 32'ha1b2c3d4, 0, T + 2);
  endtask
  task automatic test_reset_abort;
    @(negedge clk);
    valid_i = 1; op_i = MEM_LW; addr_i = 32'h300;
    @(negedge clk);
    valid_i = 0; mem_gnt_i = 1;
    @(negedge clk);
    mem_gnt_i = 0; reset = 1;
    #1;
    vec++;
    if (stall_o !== 1 || mem_req_o !== 0 || ready_o !== 0) begin
      miss++;
      $display("FAIL abort_wait: stall=%b req=%b ready=%b, required 1 0 0", stall_o, mem_req_o, ready_o);
    end
    ref_ld = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      reset = 0; mem_rvalid_i = k > 0; mem_rdata_i = $urandom;
      #1;
      vec++;
      if (ready_o !== 1 || done_o !== 0 || err_o !== 0 || load_data_o !== ref_ld) begin
        miss++;
        $display("FAIL abort cyc%0d: ready=%b done=%b err=%b ld=%h, required 1 0 0 %h",
                 k, ready_o, done_o, err_o, load_data_o, ref_ld);
      end
    end
    mem_rvalid_i = 0;
  endtask
  task automatic test_random;
    for (int i = 0; i < 60; i++)
      do_op(mem_op_e'(2'($urandom)), $urandom, $urandom, $urandom,
            int'($urandom_range(0, 3)), int'($urandom_range(0, T + 1)));
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++)
      do_op(mem_op_e'(2'(i)), {$urandom, 2'b00}, $urandom, $urandom, 0, 0);
  endtask
  initial begin
    test_reset;
    test_directed;
    test_timeout;
    test_reset_abort;
    test_random;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
